// File: rtl/load_hazard_stall_unit_if.sv
// Pipeline-side signal bundle for the load hazard stall unit.
// The master side is the pipeline, which drives the hazard inputs. The slave side is the stall unit.
interface load_hazard_stall_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic [4:0]           rs_cu;
    logic [4:0]           rt_cu;
    logic                 uses_rs_cu;
    logic                 uses_rt_cu;
    logic [5:0]           op_ex;
    logic [4:0]           rd_ex;
    logic                 register_write_ex;
    logic                 mem_req;
    logic                 mem_ready;
    logic                 branch_taken_ex;
    logic                 stall_pc;
    logic                 stall_if_id;
    logic                 bubble_id_ex;
    logic                 freeze_ex_mem;
    logic                 flush_if_id;
    logic                 mem_timeout;
    logic [CNT_WIDTH-1:0] stall_cycles;

    modport master (
        output rs_cu, rt_cu, uses_rs_cu, uses_rt_cu, op_ex, rd_ex,
               register_write_ex, mem_req, mem_ready, branch_taken_ex,
        input  stall_pc, stall_if_id, bubble_id_ex, freeze_ex_mem,
               flush_if_id, mem_timeout, stall_cycles
    );

    modport slave (
        input  rs_cu, rt_cu, uses_rs_cu, uses_rt_cu, op_ex, rd_ex,
               register_write_ex, mem_req, mem_ready, branch_taken_ex,
        output stall_pc, stall_if_id, bubble_id_ex, freeze_ex_mem,
               flush_if_id, mem_timeout, stall_cycles
    );
endinterface

// File: rtl/load_hazard_stall_unit.sv
// Stall/flush controller for a 5-stage MIPS pipeline.
// It handles load-use bubbles, memory-wait freezes, branch flushes, a memory watchdog and a stall-cycle counter.
module load_hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_WIDTH   = 32
) (
    input logic                     clk,
    input logic                     reset_n,
    load_hazard_stall_unit_if.slave bus
);
    localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [WAIT_W-1:0]    w_wait_cnt_nxt;
    logic                 r_mem_timeout;
    logic                 w_mem_timeout_nxt;
    logic [CNT_WIDTH-1:0] r_stall_cycles;

    logic w_is_load;
    logic w_load_use;
    logic w_mem_stall;
    logic w_stall;
    logic w_bubble;
    logic w_freeze;
    logic w_flush;

    // Only loads need a bubble; every other producer is covered by forwarding.
    assign w_is_load   = (bus.op_ex >= 6'd32) && (bus.op_ex <= 6'd38);
    assign w_load_use  = w_is_load && bus.register_write_ex && (bus.rd_ex != 5'd0) &&
                         ((bus.uses_rs_cu && (bus.rd_ex == bus.rs_cu)) ||
                          (bus.uses_rt_cu && (bus.rd_ex == bus.rt_cu)));
    assign w_mem_stall = bus.mem_req && !bus.mem_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_mem_timeout_nxt = r_mem_timeout;
        w_stall           = 1'b0;
        w_bubble          = 1'b0;
        w_freeze          = 1'b0;
        w_flush           = 1'b0;
        case (r_state)
            RUN: begin
                w_wait_cnt_nxt = '0;
                if (w_mem_stall) begin
                    w_stall        = 1'b1;
                    w_freeze       = 1'b1;
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = WAIT_W'(1);
                end else if (w_load_use) begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                end else if (bus.branch_taken_ex) begin
                    w_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Hazard and branch inputs are ignored here; the frozen stages hold them for RUN.
                if (bus.mem_ready) begin
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_stall  = 1'b1;
                    w_freeze = 1'b1;
                    if ((MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT))) begin
                        w_state_nxt       = HALT;
                        w_mem_timeout_nxt = 1'b1;
                    end else if (r_wait_cnt != {WAIT_W{1'b1}}) begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                    end
                end
            end
            HALT: begin
                w_stall           = 1'b1;
                w_freeze          = 1'b1;
                w_mem_timeout_nxt = 1'b1;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_mem_timeout  <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_timeout <= w_mem_timeout_nxt;
            if (w_stall && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
        end
    end

    // All outputs are forced low while reset is held.
    assign bus.stall_pc      = reset_n & w_stall;
    assign bus.stall_if_id   = reset_n & w_stall;
    assign bus.bubble_id_ex  = reset_n & w_bubble;
    assign bus.freeze_ex_mem = reset_n & w_freeze;
    assign bus.flush_if_id   = reset_n & w_flush;
    assign bus.mem_timeout   = reset_n & r_mem_timeout;
    assign bus.stall_cycles  = reset_n ? r_stall_cycles : '0;
endmodule

// File: tb/tb_load_hazard_stall_unit.sv
// Bench for load_hazard_stall_unit: directed scenarios with fixed expectations plus a randomized run against a rule-level model.
module tb_load_hazard_stall_unit;
    localparam int TMO = 4;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    load_hazard_stall_unit_if #(.CNT_WIDTH(CW)) bus ();

    load_hazard_stall_unit #(.MEM_TIMEOUT(TMO), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Vector layout: {stall_pc, stall_if_id, bubble_id_ex, freeze_ex_mem, flush_if_id, mem_timeout, stall_cycles}
    function automatic logic [8:0] act();
        return {bus.stall_pc, bus.stall_if_id, bus.bubble_id_ex, bus.freeze_ex_mem,
                bus.flush_if_id, bus.mem_timeout, bus.stall_cycles};
    endfunction

    // Model state: length of the current memory-wait episode, halted flag, stall counter
    int m_wait = 0;
    bit m_halt = 1'b0;
    int m_cnt  = 0;

    function automatic logic [8:0] model_step();
        logic sp, bub, frz, fl, to;
        bit ld, lu, ms;
        ld = (bus.op_ex >= 32) && (bus.op_ex <= 38);
        lu = ld && bus.register_write_ex && (bus.rd_ex != 0) &&
             ((bus.uses_rs_cu && bus.rd_ex == bus.rs_cu) || (bus.uses_rt_cu && bus.rd_ex == bus.rt_cu));
        ms = bus.mem_req && !bus.mem_ready;
        sp = 0; bub = 0; frz = 0; fl = 0;
        if (!reset_n) begin
            m_wait = 0; m_halt = 0; m_cnt = 0;
            return 9'd0;
        end
        to = m_halt;
        if (m_halt) begin
            sp = 1; frz = 1;
        end else if (m_wait > 0) begin
            if (bus.mem_ready) m_wait = 0;
            else begin
                sp = 1; frz = 1;
                if (m_wait == TMO) m_halt = 1;
                else m_wait++;
            end
        end else if (ms) begin
            sp = 1; frz = 1; m_wait = 1;
        end else if (lu) begin
            sp = 1; bub = 1;
        end else if (bus.branch_taken_ex) begin
            fl = 1;
        end
        model_step = {sp, sp, bub, frz, fl, to, 3'(m_cnt)};
        if (sp && m_cnt < 7) m_cnt++;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rs_cu = 0; bus.rt_cu = 0; bus.uses_rs_cu = 0; bus.uses_rt_cu = 0;
        bus.op_ex = 0; bus.rd_ex = 0; bus.register_write_ex = 0;
        bus.mem_req = 0; bus.mem_ready = 0; bus.branch_taken_ex = 0;
    endtask

    task automatic lw_hazard();
        bus.op_ex = 6'd35; bus.rd_ex = 5'd8; bus.register_write_ex = 1;
        bus.rs_cu = 5'd8; bus.uses_rs_cu = 1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        lw_hazard();
        bus.mem_req = 1; bus.branch_taken_ex = 1;
        #1;
        checks++;
        if (act() !== 9'b0) begin failures++; $display("FAIL reset_hold: got %b expected %b", act(), 9'b0); end
        tick();
        reset_n = 1;
        idle();
        #1;
        checks++;
        if (act() !== 9'b0) begin failures++; $display("FAIL reset_release: got %b expected %b", act(), 9'b0); end
    endtask

    task automatic test_load_use();
        do_reset();
        lw_hazard();
        #1;
        checks++;
        if (act() !== 9'b111000_000) begin failures++; $display("FAIL load_use: got %b expected %b", act(), 9'b111000_000); end
        tick();
        idle();
        #1;
        checks++;
        if (act() !== 9'b000000_001) begin failures++; $display("FAIL load_use_one_cycle: got %b expected %b", act(), 9'b000000_001); end
        lw_hazard(); bus.rd_ex = 0; bus.rs_cu = 0;
        #1;
        checks++;
        if (act() !== 9'b000000_001) begin failures++; $display("FAIL load_use_r0: got %b expected %b", act(), 9'b000000_001); end
        lw_hazard(); bus.uses_rs_cu = 0;
        #1;
        checks++;
        if (act() !== 9'b000000_001) begin failures++; $display("FAIL load_use_unused_rs: got %b expected %b", act(), 9'b000000_001); end
        lw_hazard(); bus.uses_rs_cu = 0; bus.rs_cu = 0; bus.rt_cu = 8; bus.uses_rt_cu = 1;
        #1;
        checks++;
        if (act() !== 9'b111000_001) begin failures++; $display("FAIL load_use_rt: got %b expected %b", act(), 9'b111000_001); end
        tick();
        idle();
        #1;
        checks++;
        if (act() !== 9'b000000_010) begin failures++; $display("FAIL load_use_count: got %b expected %b", act(), 9'b000000_010); end
    endtask

    task automatic test_non_load();
        do_reset();
        lw_hazard(); bus.op_ex = 6'd0;
        #1;
        checks++;
        if (act() !== 9'b0) begin failures++; $display("FAIL rtype_producer: got %b expected %b", act(), 9'b0); end
        lw_hazard(); bus.op_ex = 6'd43; bus.register_write_ex = 0;
        #1;
        checks++;
        if (act() !== 9'b0) begin failures++; $display("FAIL store_no_stall: got %b expected %b", act(), 9'b0); end
        lw_hazard(); bus.op_ex = 6'd39;
        #1;
        checks++;
        if (act() !== 9'b0) begin failures++; $display("FAIL opcode39_no_stall: got %b expected %b", act(), 9'b0); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (act() !== {6'b110100, 3'(i)}) begin
                failures++; $display("FAIL mem_wait_%0d: got %b expected %b", i, act(), {6'b110100, 3'(i)});
            end
            tick();
        end
        bus.mem_ready = 1;
        #1;
        checks++;
        if (act() !== 9'b000000_011) begin failures++; $display("FAIL mem_ready_cycle: got %b expected %b", act(), 9'b000000_011); end
        tick();
        idle();
        lw_hazard();
        #1;
        checks++;
        if (act() !== 9'b111000_011) begin failures++; $display("FAIL back_in_run: got %b expected %b", act(), 9'b111000_011); end
    endtask

    task automatic test_priority();
        do_reset();
        lw_hazard();
        bus.mem_req = 1; bus.mem_ready = 0; bus.branch_taken_ex = 1;
        #1;
        checks++;
        if (act() !== 9'b110100_000) begin failures++; $display("FAIL prio_mem_first: got %b expected %b", act(), 9'b110100_000); end
        tick();
        bus.mem_ready = 1;
        #1;
        checks++;
        if (act() !== 9'b000000_001) begin failures++; $display("FAIL prio_wait_ignores: got %b expected %b", act(), 9'b000000_001); end
        tick();
        bus.mem_req = 0;
        #1;
        checks++;
        if (act() !== 9'b111000_001) begin failures++; $display("FAIL prio_load_over_branch: got %b expected %b", act(), 9'b111000_001); end
        tick();
        idle();
        bus.branch_taken_ex = 1;
        #1;
        checks++;
        if (act() !== 9'b000010_010) begin failures++; $display("FAIL branch_flush: got %b expected %b", act(), 9'b000010_010); end
        tick();
        idle();
        #1;
        checks++;
        if (act() !== 9'b000000_010) begin failures++; $display("FAIL branch_one_cycle: got %b expected %b", act(), 9'b000000_010); end
    endtask

    task automatic test_watchdog();
        logic [8:0] exp;
        do_reset();
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < 9; i++) begin
            if (i >= 6) bus.mem_ready = 1;
            exp = {5'b11010, (i >= 5) ? 1'b1 : 1'b0, 3'((i > 7) ? 7 : i)};
            #1;
            checks++;
            if (act() !== exp) begin
                failures++; $display("FAIL watchdog_%0d: got %b expected %b", i, act(), exp);
            end
            tick();
        end
        reset_n = 0;
        #1;
        checks++;
        if (act() !== 9'b0) begin failures++; $display("FAIL halt_reset_hold: got %b expected %b", act(), 9'b0); end
        tick();
        reset_n = 1;
        idle();
        lw_hazard();
        #1;
        checks++;
        if (act() !== 9'b111000_000) begin failures++; $display("FAIL halt_exit: got %b expected %b", act(), 9'b111000_000); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            lw_hazard();
            tick();
            idle();
            #1;
            checks++;
            if (bus.stall_cycles !== 3'((i + 1 > 7) ? 7 : i + 1)) begin
                failures++; $display("FAIL saturation_%0d: got %0d expected %0d", i, bus.stall_cycles, (i + 1 > 7) ? 7 : i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [8:0] exp;
        ops[0] = 6'd0; ops[1] = 6'd32; ops[2] = 6'd35; ops[3] = 6'd38; ops[4] = 6'd39; ops[5] = 6'd43;
        do_reset();
        m_wait = 0; m_halt = 0; m_cnt = 0;
        for (int i = 0; i < 500; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            bus.rs_cu = 5'($urandom_range(0, 3));
            bus.rt_cu = 5'($urandom_range(0, 3));
            bus.rd_ex = 5'($urandom_range(0, 3));
            bus.uses_rs_cu = 1'($urandom_range(0, 1));
            bus.uses_rt_cu = 1'($urandom_range(0, 1));
            bus.op_ex = ops[$urandom_range(0, 5)];
            bus.register_write_ex = 1'($urandom_range(0, 1));
            bus.mem_req = ($urandom_range(0, 3) == 0);
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.branch_taken_ex = ($urandom_range(0, 3) == 0);
            #1;
            exp = model_step();
            checks++;
            if (act() !== exp) begin
                failures++; $display("FAIL random_%0d: got %b expected %b", i, act(), exp);
            end
            tick();
        end
        reset_n = 1;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_non_load();
        test_mem_wait();
        test_priority();
        test_watchdog();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
